// File: rtl/dmem_responder.sv
// dmem_responder: data-side memory responder for a single-cycle core.
// Serves a word-addressed RAM with byte/half/word stores plus an I/O page
// holding a byte output FIFO, a free-running cycle counter and a
// dropped-write counter. Reads are combinational; stores commit on clk.
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [1:0]  size,
   input  logic [31:0] aluout,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   output logic        misalign_err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [31:0]   RAM_BYTES = 32'(DEPTH_WORDS * 4);
   localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

   // Register select within the I/O page, from aluout[3:2].
   typedef enum logic [1:0] {
      REG_OUTDATA = 2'd0,
      REG_STATUS  = 2'd1,
      REG_CYCLE   = 2'd2,
      REG_DROPS   = 2'd3
   } io_reg_e;

   logic [31:0]   ram [DEPTH_WORDS];
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [3:0]    count4;
   logic [31:0]   cycle_cnt;
   logic [7:0]    drops;

   logic          is_ram;
   logic          is_io;
   io_reg_e       io_reg;
   logic [AW-1:0] ram_idx;
   logic          aligned;
   logic [3:0]    lane_en;
   logic [31:0]   lane_data;
   logic          store_ok;
   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          pop;
   logic          push_ok;
   logic          push_drop;
   logic          cycle_clr;
   logic          drops_clr;

   assign is_ram  = aluout < RAM_BYTES;
   assign is_io   = aluout[31:4] == 28'hFFFF000;
   assign io_reg  = io_reg_e'(aluout[3:2]);
   assign ram_idx = aluout[AW+1:2];

   // Alignment check and little-endian lane enables/data for the store size.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      aligned   = 1'b1;
      lane_en   = 4'b1111;
      lane_data = writedata;
      case (size)
         2'b01: begin
            aligned   = ~aluout[0];
            lane_en   = aluout[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{writedata[15:0]}};
         end
         2'b10: begin
            lane_en   = 4'b0001 << aluout[1:0];
            lane_data = {4{writedata[7:0]}};
         end
         default: begin
            aligned = (aluout[1:0] == 2'b00);
         end
      endcase
   end

   assign store_ok  = memwrite && aligned;
   assign cycle_clr = store_ok && is_io && (io_reg == REG_CYCLE);
   assign drops_clr = store_ok && is_io && (io_reg == REG_DROPS);

   // RAM lane writes on aligned stores that decode to the RAM window.
   // NOTE: the RAM array is deliberately not reset so it maps onto plain memory; only control state resets.
   always_ff @(posedge clk) begin
      if (store_ok && is_ram) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) ram[ram_idx][8*i +: 8] <= lane_data[8*i +: 8];
         end
      end
   end

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FIFO_FULL);
   assign out_valid  = ~fifo_empty;
   assign out_data   = fifo_mem[rd_ptr];
   assign count4     = 4'(count);

   assign push      = store_ok && is_io && (io_reg == REG_OUTDATA);
   assign pop       = out_valid && out_ready;
   assign push_ok   = push && (!fifo_full || pop);
   assign push_drop = push && !push_ok;

   // Output FIFO storage, pointers and occupancy; a pop frees a slot for a same-cycle push.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
         if (push_ok) begin
            fifo_mem[wr_ptr] <= writedata[7:0];
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push_ok) - CW'(pop);
      end
   end

   // Cycle counter, saturating drop counter and sticky misalignment flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_cnt    <= '0;
         drops        <= '0;
         misalign_err <= 1'b0;
      end else begin
         cycle_cnt <= cycle_clr ? 32'd0 : cycle_cnt + 32'd1;
         if (drops_clr)                         drops <= '0;
         else if (push_drop && drops != 8'hFF)  drops <= drops + 8'd1;
         if (memwrite && !aligned) misalign_err <= 1'b1;
      end
   end

   // Combinational read mux: full aligned word, zero for unmapped space.
   always_comb begin
      readdata = '0;
      if (is_ram) begin
         readdata = ram[ram_idx];
      end else if (is_io) begin
         case (io_reg)
            REG_STATUS:  readdata = {24'b0, count4, 2'b00, fifo_full, fifo_empty};
            REG_CYCLE:   readdata = cycle_cnt;
            REG_DROPS:   readdata = {24'b0, drops};
            default:     readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: inputs driven on the falling
// edge, FIFO output bytes checked against a scoreboard queue.
module tb_dmem_responder;

   localparam int          FIFO_DEPTH = 4;
   localparam logic [31:0] A_OUT   = 32'hFFFF0000;
   localparam logic [31:0] A_STAT  = 32'hFFFF0004;
   localparam logic [31:0] A_CYC   = 32'hFFFF0008;
   localparam logic [31:0] A_DROPS = 32'hFFFF000C;
   localparam logic [1:0]  SZ_W = 2'b00;
   localparam logic [1:0]  SZ_H = 2'b01;
   localparam logic [1:0]  SZ_B = 2'b10;

   logic        clk;
   logic        reset;
   logic        memwrite;
   logic [1:0]  size;
   logic [31:0] aluout;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        misalign_err;

   int          checks;
   int          failures;
   int          exp_drops;
   logic [7:0]  sb [$];

   dmem_responder #(.DEPTH_WORDS(64), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .memwrite     (memwrite),
      .size         (size),
      .aluout       (aluout),
      .writedata    (writedata),
      .readdata     (readdata),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .misalign_err (misalign_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Scoreboard monitor: every handshake pops the oldest expected byte.
   always @(negedge clk) begin
      logic [7:0] exp_b;
      #2;
      if (reset && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL pop_unexpected: out_data=%h popped, expected no pop", out_data);
         end else begin
            exp_b = sb.pop_front();
            if (out_data !== exp_b) begin
               failures++;
               $display("FAIL pop_data: out_data=%h expected %h", out_data, exp_b);
            end
         end
      end
   end

   // Global time bound.
   initial begin
      #1_000_000;
      failures++;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
      @(negedge clk);
      memwrite  = 1'b1;
      aluout    = a;
      writedata = d;
      size      = s;
      @(negedge clk);
      memwrite  = 1'b0;
   endtask

   // Combinational read; caller is in the low phase of clk.
   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      memwrite = 1'b0;
      aluout   = a;
      #1;
      d = readdata;
   endtask

   // Push with out_ready held low; the bench model decides accept or drop.
   task automatic push_byte(input logic [7:0] b);
      store(A_OUT, {24'b0, b}, SZ_B);
      if (sb.size() < FIFO_DEPTH) sb.push_back(b);
      else if (exp_drops < 255) exp_drops++;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      rd(A_STAT, d);
      checks++;
      if (d !== 32'h1) begin failures++; $display("FAIL reset_status: got %h expected %h", d, 32'h1); end
      checks++;
      if (out_valid !== 1'b0 || misalign_err !== 1'b0 || out_data !== 8'h00) begin
         failures++;
         $display("FAIL reset_outputs: valid=%b err=%b data=%h expected 0 0 00", out_valid, misalign_err, out_data);
      end
   endtask

   task automatic test_ram_lanes();
      logic [31:0] d;
      store(32'h10, 32'hDEADBEEF, SZ_W);
      store(32'h11, 32'h00000055, SZ_B);
      store(32'h12, 32'h0000A1B2, SZ_H);
      rd(32'h10, d);
      checks++;
      if (d !== 32'hA1B255EF) begin failures++; $display("FAIL ram_lanes: got %h expected %h", d, 32'hA1B255EF); end
      store(32'hFC, 32'h12345678, SZ_W);
      store(32'hFE, 32'h00009ABC, SZ_H);
      rd(32'hFC, d);
      checks++;
      if (d !== 32'h9ABC5678) begin failures++; $display("FAIL ram_top_word: got %h expected %h", d, 32'h9ABC5678); end
      rd(32'h100, d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL past_ram_read: got %h expected %h", d, 32'h0); end
   endtask

   task automatic test_misalign();
      logic [31:0] d;
      store(32'h13, 32'h0000FFFF, SZ_H);
      rd(32'h10, d);
      checks++;
      if (d !== 32'hA1B255EF) begin failures++; $display("FAIL misalign_half_nowrite: got %h expected %h", d, 32'hA1B255EF); end
      checks++;
      if (misalign_err !== 1'b1) begin failures++; $display("FAIL misalign_set: got %b expected 1", misalign_err); end
      store(32'h12, 32'h01020304, SZ_W);
      store(32'h20, 32'h0000CAFE, SZ_W);
      rd(32'h10, d);
      checks++;
      if (d !== 32'hA1B255EF || misalign_err !== 1'b1) begin
         failures++;
         $display("FAIL misalign_word_sticky: word=%h err=%b expected %h 1", d, misalign_err, 32'hA1B255EF);
      end
      store(32'h0, 32'h11111111, SZ_W);
      store(32'h200, 32'hCAFEF00D, SZ_W);
      rd(32'h200, d);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read: got %h expected %h", d, 32'h0); end
      rd(32'h0, d);
      checks++;
      if (d !== 32'h11111111) begin failures++; $display("FAIL unmapped_no_alias: got %h expected %h", d, 32'h11111111); end
   endtask

   task automatic test_fifo_full_drain();
      logic [31:0] d;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_byte(8'(8'h41 + i));
      rd(A_STAT, d);
      checks++;
      if (d !== 32'h42) begin failures++; $display("FAIL status_full: got %h expected %h", d, 32'h42); end
      rd(A_DROPS, d);
      checks++;
      if (d !== 32'(exp_drops)) begin failures++; $display("FAIL drops_one: got %h expected %h", d, 32'(exp_drops)); end
      checks++;
      if (out_data !== sb[0] || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL head_visible: valid=%b data=%h expected 1 %h", out_valid, out_data, sb[0]);
      end
      @(negedge clk);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #3;
         checks++;
         if (out_valid !== 1'b1) begin failures++; $display("FAIL drain_valid_%0d: got %b expected 1", k, out_valid); end
         @(negedge clk);
      end
      #3;
      checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         failures++;
         $display("FAIL drain_done: valid=%b left=%0d expected 0 0", out_valid, sb.size());
      end
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_full_push_pop();
      logic [31:0] d;
      for (int i = 0; i < 4; i++) push_byte(8'(8'h61 + i));
      @(negedge clk);
      out_ready = 1'b1;
      memwrite  = 1'b1;
      aluout    = A_OUT;
      writedata = 32'h99;
      size      = SZ_B;
      sb.push_back(8'h99);
      @(negedge clk);
      memwrite  = 1'b0;
      out_ready = 1'b0;
      rd(A_STAT, d);
      checks++;
      if (d !== 32'h42) begin failures++; $display("FAIL pushpop_count: got %h expected %h", d, 32'h42); end
      rd(A_DROPS, d);
      checks++;
      if (d !== 32'(exp_drops)) begin failures++; $display("FAIL pushpop_drops: got %h expected %h", d, 32'(exp_drops)); end
      @(negedge clk);
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      out_ready = 1'b0;
      #3;
      checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         failures++;
         $display("FAIL pushpop_drain: valid=%b left=%0d expected 0 0", out_valid, sb.size());
      end
   endtask

   task automatic test_drops_saturate();
      logic [31:0] d;
      for (int i = 0; i < FIFO_DEPTH + 256; i++) push_byte(8'(i));
      rd(A_DROPS, d);
      checks++;
      if (d !== 32'(exp_drops)) begin failures++; $display("FAIL drops_saturate: got %h expected %h", d, 32'(exp_drops)); end
      store(A_DROPS, 32'hFFFFFFFF, SZ_W);
      exp_drops = 0;
      rd(A_DROPS, d);
      checks++;
      if (d !== 32'(exp_drops)) begin failures++; $display("FAIL drops_clear: got %h expected %h", d, 32'(exp_drops)); end
      @(negedge clk);
      out_ready = 1'b1;
      repeat (6) @(negedge clk);
      out_ready = 1'b0;
      #3;
      checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         failures++;
         $display("FAIL drops_drain: valid=%b left=%0d expected 0 0", out_valid, sb.size());
      end
   endtask

   task automatic test_cycle();
      logic [31:0] c0;
      logic [31:0] c1;
      @(negedge clk);
      rd(A_CYC, c0);
      repeat (10) @(negedge clk);
      rd(A_CYC, c1);
      checks++;
      if (c1 - c0 !== 32'd10) begin failures++; $display("FAIL cycle_delta: got %0d expected 10", c1 - c0); end
      store(A_CYC, 32'h12345678, SZ_W);
      rd(A_CYC, c0);
      checks++;
      if (c0 !== 32'd0) begin failures++; $display("FAIL cycle_clear: got %h expected %h", c0, 32'd0); end
      @(negedge clk);
      rd(A_CYC, c1);
      checks++;
      if (c1 !== 32'd1) begin failures++; $display("FAIL cycle_after_clear: got %h expected %h", c1, 32'd1); end
   endtask

   task automatic test_reset_midop();
      logic [31:0] d;
      out_ready = 1'b0;
      push_byte(8'h71);
      push_byte(8'h72);
      @(negedge clk);
      #2;
      checks++;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL midop_queued: got %b expected 1", out_valid); end
      reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 8'h00) begin
         failures++;
         $display("FAIL midop_async: valid=%b data=%h expected 0 00", out_valid, out_data);
      end
      sb.delete();
      exp_drops = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      rd(A_STAT, d);
      checks++;
      if (d !== 32'h1) begin failures++; $display("FAIL midop_status: got %h expected %h", d, 32'h1); end
      checks++;
      if (misalign_err !== 1'b0) begin failures++; $display("FAIL midop_err_cleared: got %b expected 0", misalign_err); end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      exp_drops = 0;
      reset     = 1'b0;
      memwrite  = 1'b0;
      size      = 2'b00;
      aluout    = '0;
      writedata = '0;
      out_ready = 1'b0;
      test_reset();
      test_ram_lanes();
      test_misalign();
      test_fifo_full_drain();
      test_full_push_pop();
      test_drops_saturate();
      test_cycle();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
